aes_round_ctrl: RTL and testbench
=================================

AES_ROUND_CTRL -- requirements
Module: aes_round_ctrl

Interface
REQ-001 Parameter KEY_WIDTH, default 128, is the key size in bits; 128 gives NUM_ROUNDS=10, and any other value gives NUM_ROUNDS=14.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 in_valid  input  1  a plaintext block and key are present at the datapath inputs.
REQ-005 in_ready  output  1  controller can accept a block.
REQ-006 key_new  input  1  the key input has changed, so the round-key schedule must be regenerated.
REQ-007 kx_start  output  1  one-cycle request to the key-expansion unit.
REQ-008 kx_done  input  1  key-expansion unit has finished.
REQ-009 ld_state  output  1  datapath loads state = data_in XOR round key 0.
REQ-010 round_en  output  1  datapath performs one round on the state register.
REQ-011 final_round  output  1  current round omits MixColumns.
REQ-012 round_idx  output  4  round-key select for the key schedule.
REQ-013 out_valid  output  1  ciphertext at data_out is valid.
REQ-014 out_ready  input  1  downstream accepts the ciphertext.
REQ-015 busy  output  1  a block is in progress.

Function
REQ-016 The controller SHALL be a Moore FSM with states IDLE, KX, LOAD, RUN, FINAL and DONE; every output SHALL be decoded from the state register and the round counter only.
REQ-017 IDLE: in_ready=1 and busy=0; all other outputs 0; round_idx=0.
REQ-018 Accept = in_valid & in_ready at a rising edge; on accept the FSM SHALL go to KX if key_stale=1, else to LOAD.
REQ-019 key_stale SHALL be a flag that reset sets to 1; key_new=1 in any state sets it; kx_done=1 while in KX clears it.
REQ-020 If key_new=1 and the clearing kx_done arrive in the same cycle, key_stale SHALL remain 1.
REQ-021 KX: kx_start=1 in the first KX cycle only; the FSM SHALL wait in KX until kx_done=1, then go to LOAD.
REQ-022 kx_done arriving in any state other than KX SHALL be ignored.
REQ-023 LOAD: ld_state=1 and round_idx=0 for exactly one cycle; next state RUN with round_idx=1.
REQ-024 RUN: round_en=1; round_idx SHALL increment by 1 each cycle; when round_idx=NUM_ROUNDS-1 the next state SHALL be FINAL.
REQ-025 FINAL: round_en=1, final_round=1 and round_idx=NUM_ROUNDS for one cycle; next state DONE.
REQ-026 DONE: out_valid=1, held until out_ready=1; then the FSM SHALL return to IDLE and round_idx SHALL return to 0.
REQ-027 busy=1 in every state except IDLE; in_ready=0 in every state except IDLE, so there is no back-to-back accept from DONE.
REQ-028 Latency without expansion: with accept at edge T, out_valid SHALL rise at edge T+NUM_ROUNDS+2.
REQ-029 Latency with expansion: latency SHALL equal the REQ-028 latency plus the number of cycles spent in KX.
REQ-030 key_new asserted mid-block SHALL NOT disturb the current block, which completes with the existing schedule; the next accepted block SHALL go through KX.
REQ-031 round_idx SHALL never exceed NUM_ROUNDS; the round counter SHALL NOT wrap.
REQ-032 ld_state, round_en and kx_start SHALL be mutually exclusive.

Reset
REQ-033 While rst=1, regardless of clk: state=IDLE, round_idx=0, key_stale=1, and all outputs 0 except in_ready=1.
REQ-034 rst asserted mid-operation SHALL abort the block with no out_valid; the first accept after rst deasserts SHALL go through KX.

Verification
REQ-035 Reset, KEY_WIDTH=128, in_valid=1 at T, kx_done=1 at T+3 -> kx_start only at T+1; LOAD at T+4; round_idx 1..9 at T+5..T+13; FINAL with idx 10 at T+14; out_valid at T+15.
REQ-036 Second block, same key, out_ready=1 -> no kx_start; out_valid exactly 12 cycles after accept; in_ready=0 throughout.
REQ-037 KEY_WIDTH=256, key_stale=0 -> 13 round_en cycles with idx 1..13, then FINAL with idx 14; out_valid 16 cycles after accept.
REQ-038 out_ready=0 for 5 cycles in DONE -> out_valid held for 6 cycles; IDLE on the cycle after out_ready=1.
REQ-039 key_new pulsed in RUN, then next accept -> current block is unaffected; next block enters KX and kx_start pulses once.
REQ-040 rst pulsed in RUN at round_idx=5 -> in_ready=1 and idx=0 immediately with no out_valid; kx_done in IDLE is ignored; the next accept enters KX.

Source files
------------

// File: rtl/aes_round_ctrl.sv
// Round sequencer for an iterative AES datapath: optional key expansion, the
// initial AddRoundKey load, NUM_ROUNDS-1 full rounds, one final round, then output.
module aes_round_ctrl #(
  parameter int KEY_WIDTH = 128
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       key_new,
  output logic       kx_start,
  input  logic       kx_done,
  output logic       ld_state,
  output logic       round_en,
  output logic       final_round,
  output logic [3:0] round_idx,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy,
  output logic [2:0] state_dbg
);

  localparam logic [3:0] NUM_ROUNDS = (KEY_WIDTH == 128) ? 4'd10 : 4'd14;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_KX    = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_RUN   = 3'd3;
  localparam logic [2:0] S_FINAL = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic [2:0] state, state_nx;
  logic [3:0] cnt, cnt_nx;
  logic       key_stale;

  // Handshakes: a block is taken when in_valid & in_ready at a rising edge; the
  // result leaves when out_valid & out_ready at a rising edge.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      S_IDLE: begin
        cnt_nx = 4'd0;
        if (in_valid) state_nx = key_stale ? S_KX : S_LOAD;
      end
      // In KX the counter marks whether the expansion request has been issued.
      S_KX: begin
        if (kx_done) begin
          state_nx = S_LOAD;
          cnt_nx   = 4'd0;
        end else begin
          cnt_nx = 4'd1;
        end
      end
      S_LOAD: begin
        state_nx = S_RUN;
        cnt_nx   = 4'd1;
      end
      S_RUN: begin
        cnt_nx = cnt + 4'd1;
        if (cnt == NUM_ROUNDS - 4'd1) state_nx = S_FINAL;
      end
      S_FINAL: state_nx = S_DONE;
      S_DONE: begin
        if (out_ready) begin
          state_nx = S_IDLE;
          cnt_nx   = 4'd0;
        end
      end
      default: begin
        state_nx = S_IDLE;
        cnt_nx   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // A key change always wins over a completing expansion of the older key.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                            key_stale <= 1'b1;
    else if (key_new)                   key_stale <= 1'b1;
    else if (state == S_KX && kx_done)  key_stale <= 1'b0;
  end

  assign in_ready    = (state == S_IDLE);
  assign busy        = (state != S_IDLE);
  assign kx_start    = (state == S_KX) && (cnt == 4'd0);
  assign ld_state    = (state == S_LOAD);
  assign round_en    = (state == S_RUN) || (state == S_FINAL);
  assign final_round = (state == S_FINAL);
  assign out_valid   = (state == S_DONE);
  assign round_idx   = (state == S_KX) ? 4'd0 : cnt;
  assign state_dbg   = state;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Bench for aes_round_ctrl: a 128-bit and a 256-bit instance checked every cycle
// against a per-block timeline model (KX length, load, rounds, final, output hold).
module tb_aes_round_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       in_valid[2], key_new[2], kx_done[2], out_ready[2];
  logic       in_ready[2], kx_start[2], ld_state[2], round_en[2];
  logic       final_round[2], out_valid[2], busy[2];
  logic [3:0] round_idx[2];
  logic [2:0] state_dbg[2];

  aes_round_ctrl #(.KEY_WIDTH(128)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .key_new(key_new[0]), .kx_start(kx_start[0]), .kx_done(kx_done[0]),
    .ld_state(ld_state[0]), .round_en(round_en[0]), .final_round(final_round[0]),
    .round_idx(round_idx[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .busy(busy[0]), .state_dbg(state_dbg[0])
  );

  aes_round_ctrl #(.KEY_WIDTH(256)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .key_new(key_new[1]), .kx_start(kx_start[1]), .kx_done(kx_done[1]),
    .ld_state(ld_state[1]), .round_en(round_en[1]), .final_round(final_round[1]),
    .round_idx(round_idx[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .busy(busy[1]), .state_dbg(state_dbg[1])
  );

  int checks = 0;
  int passed = 0;
  int failed = 0;
  bit stale_m[2];

  function automatic logic [6:0] flags(int d);
    return {in_ready[d], busy[d], kx_start[d], ld_state[d], round_en[d],
            final_round[d], out_valid[d]};
  endfunction

  task automatic check_flags(string tag, int d, logic [6:0] exp);
    checks++;
    assert (flags(d) === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s dut%0d flags observed=%b expected=%b", tag, d, flags(d), exp);
    end
  endtask

  task automatic check_idx(string tag, int d, logic [3:0] exp);
    checks++;
    assert (round_idx[d] === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s dut%0d round_idx observed=%0d expected=%0d", tag, d, round_idx[d], exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_check(string tag, int d);
    check_flags(tag, d, 7'b1000000);
    check_idx(tag, d, 4'd0);
  endtask

  task automatic clear_inputs();
    for (int i = 0; i < 2; i++) begin
      in_valid[i] = 1'b0; key_new[i] = 1'b0; kx_done[i] = 1'b0; out_ready[i] = 1'b0;
    end
  endtask

  task automatic idle_kx_done(int d);
    kx_done[d] = 1'b1;
    step();
    kx_done[d] = 1'b0;
    idle_check("idle_kx_done", d);
  endtask

  task automatic idle_key_new(int d);
    key_new[d] = 1'b1;
    stale_m[d] = 1'b1;
    step();
    key_new[d] = 1'b0;
    idle_check("idle_key_new", d);
  endtask

  // One block: kx_lat = cycles spent in KX if the key is stale, hold = cycles
  // out_ready stays low in DONE, kn_at/abort_j = cycle index for a key_new
  // pulse / a reset (0 = none). Cycle j counts edges since the accept edge.
  task automatic run_block(int d, int kx_lat, int hold, int kn_at, int abort_j);
    int n, k, last;
    logic [6:0] ef;
    n = (d == 0) ? 10 : 14;
    idle_check("pre_accept", d);
    k = stale_m[d] ? kx_lat : 0;
    last = k + n + 2 + hold;
    in_valid[d] = 1'b1;
    step();
    in_valid[d] = 1'b0;
    for (int j = 1; j <= last; j++) begin
      if (j <= k) begin
        ef = {5'b01000, 2'b00} | ((j == 1) ? 7'b0010000 : 7'b0);
        check_flags("kx", d, ef);
      end else if (j == k + 1) begin
        check_flags("load", d, 7'b0101000);
        check_idx("load", d, 4'd0);
      end else if (j <= k + n) begin
        check_flags("run", d, 7'b0100100);
        check_idx("run", d, 4'(j - k - 1));
      end else if (j == k + n + 1) begin
        check_flags("final", d, 7'b0100110);
        check_idx("final", d, 4'(n));
      end else begin
        check_flags("done", d, 7'b0100001);
      end
      if (j == abort_j) begin
        #2 rst = 1'b1;
        clear_inputs();
        #1;
        idle_check("abort_async", d);
        stale_m[0] = 1'b1;
        stale_m[1] = 1'b1;
        step();
        idle_check("abort_held", d);
        rst = 1'b0;
        return;
      end
      key_new[d]   = (j == kn_at);
      kx_done[d]   = (k > 0 && j == k);
      out_ready[d] = (j == last);
      if (j == kn_at) stale_m[d] = 1'b1;
      else if (k > 0 && j == k) stale_m[d] = 1'b0;
      step();
    end
    clear_inputs();
    idle_check("return_idle", d);
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    stale_m[0] = 1'b1;
    stale_m[1] = 1'b1;
    #2;
    idle_check("reset_async", 0);
    idle_check("reset_async", 1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    idle_check("after_reset", 0);
    idle_check("after_reset", 1);

    // 128-bit directed sequence
    idle_kx_done(0);
    run_block(0, 3, 0, 0, 0);
    run_block(0, 1, 0, 0, 0);
    run_block(0, 1, 5, 0, 0);
    run_block(0, 1, $urandom_range(0, 3), 6, 0);
    run_block(0, $urandom_range(1, 4), 0, 0, 0);
    idle_key_new(0);
    run_block(0, 2, 0, 2, 0);
    run_block(0, 1, 0, 0, 0);
    run_block(0, 1, 0, 0, 6);
    idle_kx_done(0);
    run_block(0, 2, 0, 0, 0);

    // 256-bit directed sequence
    run_block(1, $urandom_range(1, 4), 0, 0, 0);
    run_block(1, 1, 0, 0, 0);
    run_block(1, 1, 2, 9, 0);

    // randomized blocks on both widths
    for (int i = 0; i < 6; i++) begin
      for (int d = 0; d < 2; d++) begin
        run_block(d, $urandom_range(1, 4), $urandom_range(0, 3), $urandom_range(0, 20), 0);
      end
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
